// File: rtl/sum_display_driver.sv
// ---------------------------------------------------------------------------
// sum_display_driver
//   Captures the 5-bit result of the 4-bit adder on a load strobe, converts it
//   to two BCD digits with a sequential shift-add-3 (double-dabble) engine and
//   drives the two rightmost digits of the Nexys A7 8-digit common-anode
//   7-segment display, time-multiplexed by a free-running refresh counter.
//
// Ports:
//   clk   in   1  system clock (100 MHz)
//   rst   in   1  synchronous active-high reset
//   sum   in   5  adder result, 0..31
//   load  in   1  capture strobe, sampled only while idle
//   busy  out  1  high while a conversion is in progress
//   seg   out  7  cathodes {g,f,e,d,c,b,a}, active low
//   dp    out  1  decimal point, active low, held off
//   an    out  8  anodes, active low; only an[1:0] are ever driven low
// ---------------------------------------------------------------------------
module sum_display_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] sum,
  input  logic       load,
  output logic       busy,
  output logic [6:0] seg,
  output logic       dp,
  output logic [7:0] an
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [12:0] shift_reg, shift_next;   // {tens[3:0], ones[3:0], bin[4:0]}
  logic [12:0] adj;
  logic [2:0]  iter_reg, iter_next;
  logic [3:0]  tens_reg, tens_next;
  logic [3:0]  ones_reg, ones_next;
  logic        busy_reg;

  logic [CW-1:0] cnt_reg;
  logic          sel_reg;
  logic [6:0]    seg_reg, seg_next;
  logic [7:0]    an_reg, an_next;

  function automatic logic [6:0] pattern(input logic [3:0] d);
    case (d)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = 7'b1111111;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Conversion FSM: next-state and datapath
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    iter_next  = iter_reg;
    tens_next  = tens_reg;
    ones_next  = ones_reg;

    // Add-3 correction on each BCD nibble before the shift.
    adj = shift_reg;
    if (shift_reg[12:9] >= 4'd5) adj[12:9] = shift_reg[12:9] + 4'd3;
    if (shift_reg[8:5]  >= 4'd5) adj[8:5]  = shift_reg[8:5]  + 4'd3;

    case (state_reg)
      IDLE: begin
        if (load) begin
          shift_next = {8'd0, sum};
          iter_next  = 3'd0;
          state_next = CONV;
        end
      end
      CONV: begin
        shift_next = {adj[11:0], 1'b0};
        iter_next  = iter_reg + 3'd1;
        if (iter_reg == 3'd4) state_next = DONE;
      end
      DONE: begin
        tens_next  = shift_reg[12:9];
        ones_next  = shift_reg[8:5];
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      shift_reg <= 13'd0;
      iter_reg  <= 3'd0;
      tens_reg  <= 4'd0;
      ones_reg  <= 4'd0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      iter_reg  <= iter_next;
      tens_reg  <= tens_next;
      ones_reg  <= ones_next;
      busy_reg  <= (state_next != IDLE);
    end
  end

  // ---------------------------------------------------------------------
  // Refresh counter: free running, toggles the digit select on wrap
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      sel_reg <= 1'b0;
    end else if (cnt_reg == TERMINAL) begin
      cnt_reg <= '0;
      sel_reg <= ~sel_reg;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Output decode, registered. Digits only change in DONE, so partial
  // conversion results are never visible.
  // ---------------------------------------------------------------------
  always_comb begin
    an_next  = 8'hFE;
    seg_next = pattern(ones_reg);
    if (sel_reg) begin
      if (BLANK_LZ && (tens_reg == 4'd0)) begin
        an_next  = 8'hFF;
        seg_next = 7'b1111111;
      end else begin
        an_next  = 8'hFD;
        seg_next = pattern(tens_reg);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_reg  <= 8'hFE;
      seg_reg <= 7'b1000000;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
    end
  end

  assign busy = busy_reg;
  assign seg  = seg_reg;
  assign an   = an_reg;
  assign dp   = 1'b1;

endmodule

// File: tb/tb_sum_display_driver.sv
// ---------------------------------------------------------------------------
// tb_sum_display_driver
//   Directed bench for sum_display_driver with REFRESH_DIV = 4. Two instances
//   share the inputs: u_blank (BLANK_LZ = 1) and u_show (BLANK_LZ = 0).
//   Expected digit pairs are queued when a load is driven and popped when the
//   display is inspected after the conversion completes.
// ---------------------------------------------------------------------------
module tb_sum_display_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] sum;
  logic       load;
  logic       busy1, busy0;
  logic [6:0] seg1, seg0;
  logic       dp1, dp0;
  logic [7:0] an1, an0;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  sum_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) u_blank (
    .clk(clk), .rst(rst), .sum(sum), .load(load),
    .busy(busy1), .seg(seg1), .dp(dp1), .an(an1)
  );

  sum_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) u_show (
    .clk(clk), .rst(rst), .sum(sum), .load(load),
    .busy(busy0), .seg(seg0), .dp(dp0), .an(an0)
  );

  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b1111111;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input logic [4:0] s);
    logic [7:0] r;
    r[7:4] = 4'(s / 10);
    r[3:0] = 4'(s % 10);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one load at the next edge; optionally keep load high for 'hold'
  // extra edges while presenting s2 on sum. Measures busy width.
  task automatic run_conv(input logic [4:0] s, input int hold, input logic [4:0] s2);
    int width;
    width = 0;
    sum  = s;
    load = 1'b1;
    exp_q.push_back(to_bcd(s));
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) sum = s2;
      if (c >= hold) load = 1'b0;
      chk("busy_match", 32'(busy0), 32'(busy1));
      if (busy1) width++;
      else break;
    end
    load = 1'b0;
    chk($sformatf("busy_width sum=%0d", s), width, 6);
    $display("conv sum=%0d busy_width=%0d", s, width);
  endtask

  // Inspect both display slots over a full refresh period.
  task automatic check_display(input string tag);
    logic [7:0] e;
    logic [3:0] t, o;
    logic       so1, st1, so0, st0;
    logic [6:0] o_seg1, t_seg1, o_seg0, t_seg0;
    logic [7:0] t_an1, t_an0;
    // Only the newest result survives on the display.
    while (exp_q.size() > 1) void'(exp_q.pop_front());
    chk({tag, " sb_depth"}, exp_q.size(), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    t = e[7:4];
    o = e[3:0];
    {so1, st1, so0, st0} = 4'b0;
    {o_seg1, t_seg1, o_seg0, t_seg0} = '0;
    t_an1 = 8'h00;
    t_an0 = 8'h00;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (an1 == 8'hFE) begin so1 = 1'b1; o_seg1 = seg1; end
      else begin st1 = 1'b1; t_an1 = an1; t_seg1 = seg1; end
      if (an0 == 8'hFE) begin so0 = 1'b1; o_seg0 = seg0; end
      else begin st0 = 1'b1; t_an0 = an0; t_seg0 = seg0; end
    end
    chk({tag, " dp"}, {dp1, dp0}, 2'b11);
    chk({tag, " slots_seen"}, {so1, st1, so0, st0}, 4'b1111);
    chk({tag, " ones_seg_blank"}, o_seg1, pat(o));
    chk({tag, " ones_seg_show"}, o_seg0, pat(o));
    chk({tag, " tens_an_blank"}, t_an1, (t == 4'd0) ? 8'hFF : 8'hFD);
    chk({tag, " tens_seg_blank"}, t_seg1, (t == 4'd0) ? 7'b1111111 : pat(t));
    chk({tag, " tens_an_show"}, t_an0, 8'hFD);
    chk({tag, " tens_seg_show"}, t_seg0, pat(t));
    $display("display %s expect tens=%0d ones=%0d seg_ones=%b seg_tens=%b an_tens=%h",
             tag, t, o, o_seg0, t_seg0, t_an1);
  endtask

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    sum  = 5'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {busy1, busy0}, 2'b00);
    chk("rst_an", {an1, an0}, 16'hFEFE);
    chk("rst_seg", {seg1, seg0}, {7'b1000000, 7'b1000000});
    chk("rst_dp", {dp1, dp0}, 2'b11);
    $display("reset an=%h seg=%b", an1, seg1);
    rst = 1'b0;

    // Refresh alternation: slot output lags the select by one edge.
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("refresh_an_blank k=%0d", k), an1, (((k - 1) / 4) % 2 == 1) ? 8'hFF : 8'hFE);
      chk($sformatf("refresh_an_show k=%0d", k), an0, (((k - 1) / 4) % 2 == 1) ? 8'hFD : 8'hFE);
      chk($sformatf("refresh_seg_show k=%0d", k), seg0, 7'b1000000);
      $display("refresh k=%0d an_blank=%h an_show=%h", k, an1, an0);
    end

    // 30 -> "30"
    run_conv(5'd30, 0, 5'd30);
    check_display("sum30");

    // 9 -> tens blanked on one instance, shown as 0 on the other
    run_conv(5'd9, 0, 5'd9);
    check_display("sum9");

    // Loads held during conversion are ignored; sum changes after capture ignored
    run_conv(5'd12, 5, 5'd25);
    check_display("sum12_busy_load");

    // Back-to-back: second load lands exactly on E7
    run_conv(5'd3, 0, 5'd3);
    run_conv(5'd25, 0, 5'd25);
    check_display("sum25_e7");

    // Reset mid-conversion at E3
    sum  = 5'd31;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    sum  = 5'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {busy1, busy0}, 2'b00);
    chk("midrst_an", {an1, an0}, 16'hFEFE);
    chk("midrst_seg", {seg1, seg0}, {7'b1000000, 7'b1000000});
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy_after", {busy1, busy0}, 2'b00);
    chk("midrst_seg_after", {seg1, seg0}, {7'b1000000, 7'b1000000});
    $display("midreset busy=%b an=%h seg=%b", busy1, an1, seg1);
    run_conv(5'd31, 0, 5'd31);
    check_display("sum31_after_rst");

    // Exhaustive sweep
    for (int s = 0; s < 32; s++) begin
      run_conv(5'(s), 0, 5'(s));
      check_display($sformatf("sweep%0d", s));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
